// File: rtl/dual_mod_exp_pkg.sv
// Shared definitions for the dual-base modular exponentiator:
// FSM states, multiplier operand-select codes and index-width helper.
package dual_mod_exp_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      PRE_ISSUE = 3'd1,
      PRE_CAP   = 3'd2,
      SQ_ISSUE  = 3'd3,
      SQ_CAP    = 3'd4,
      MUL_ISSUE = 3'd5,
      MUL_CAP   = 3'd6,
      OUT       = 3'd7
   } state_t;

   // {exp0[i], exp1[i]} selects the multiplicand of the MUL step
   localparam logic [1:0] SEL_NONE = 2'b00;
   localparam logic [1:0] SEL_B0   = 2'b10;
   localparam logic [1:0] SEL_B1   = 2'b01;
   localparam logic [1:0] SEL_B01  = 2'b11;

   function automatic int idx_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/dual_mod_exp_if.sv
// Operand/result handshake bundle for dual_mod_exp.
interface dual_mod_exp_if #(
   parameter int LEN     = 32,
   parameter int EXP_LEN = 32
);
   logic               in_valid;
   logic               in_ready;
   logic [LEN-1:0]     base0;
   logic [LEN-1:0]     base1;
   logic [EXP_LEN-1:0] exp0;
   logic [EXP_LEN-1:0] exp1;
   logic [LEN-1:0]     modulus;
   logic               out_valid;
   logic               out_ready;
   logic [LEN-1:0]     result;
   logic               busy;

   modport master (
      output in_valid, base0, base1, exp0, exp1, modulus, out_ready,
      input  in_ready, out_valid, result, busy
   );

   modport slave (
      input  in_valid, base0, base1, exp0, exp1, modulus, out_ready,
      output in_ready, out_valid, result, busy
   );
endinterface

// File: rtl/dual_mod_exp_mod_mul.sv
// Combinational modular multiply: c = (a * b) mod r, full 2*LEN-bit product.
module mod_mul #(
   parameter int LEN = 32
) (
   input  logic [LEN-1:0] a,
   input  logic [LEN-1:0] b,
   input  logic [LEN-1:0] r,
   output logic [LEN-1:0] c
);
   logic [2*LEN-1:0] prod;
   logic [2*LEN-1:0] rem;

   assign prod = {{LEN{1'b0}}, a} * {{LEN{1'b0}}, b};
   assign rem  = prod % {{LEN{1'b0}}, r};
   assign c    = rem[LEN-1:0];
endmodule

// File: rtl/dual_mod_exp.sv
// Shamir's-trick dual exponentiator: (base0^exp0 * base1^exp1) mod modulus,
// MSB-first, one time-shared mod_mul with a 2-cycle issue/capture step.
module dual_mod_exp
   import dual_mod_exp_pkg::*;
#(
   parameter int LEN     = 32,
   parameter int EXP_LEN = 32
) (
   input logic          clk,
   input logic          rst,
   dual_mod_exp_if.slave bus
);
   localparam int IW = idx_w(EXP_LEN);

   state_t             state, state_nx;
   logic [LEN-1:0]     b0_q, b1_q, m_q, b01_q, acc_q;
   logic [LEN-1:0]     mul_a, mul_b, mul_c;
   logic [LEN-1:0]     result_q;
   logic [EXP_LEN-1:0] e0_q, e1_q;
   logic [IW-1:0]      idx_q;
   logic               out_valid_q;
   logic [1:0]         bits;
   logic               accept, last_bit;

   assign accept   = bus.in_valid && (state == IDLE);
   assign bits     = {e0_q[idx_q], e1_q[idx_q]};
   assign last_bit = (idx_q == '0);

   mod_mul #(.LEN(LEN)) u_mul (.a(mul_a), .b(mul_b), .r(m_q), .c(mul_c));

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:      if (accept) state_nx = (bus.modulus <= LEN'(1)) ? OUT : PRE_ISSUE;
         PRE_ISSUE: state_nx = PRE_CAP;
         PRE_CAP:   state_nx = SQ_ISSUE;
         SQ_ISSUE:  state_nx = SQ_CAP;
         SQ_CAP:    state_nx = (bits != SEL_NONE) ? MUL_ISSUE : (last_bit ? OUT : SQ_ISSUE);
         MUL_ISSUE: state_nx = MUL_CAP;
         MUL_CAP:   state_nx = last_bit ? OUT : SQ_ISSUE;
         OUT:       if (out_valid_q && bus.out_ready) state_nx = IDLE;
         default:   state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         acc_q       <= '0;
         b0_q        <= '0;
         b1_q        <= '0;
         b01_q       <= '0;
         m_q         <= '0;
         e0_q        <= '0;
         e1_q        <= '0;
         idx_q       <= '0;
         mul_a       <= '0;
         mul_b       <= '0;
      end else begin
         state <= state_nx;
         case (state)
            IDLE: if (accept) begin
               b0_q  <= bus.base0;
               b1_q  <= bus.base1;
               e0_q  <= bus.exp0;
               e1_q  <= bus.exp1;
               m_q   <= bus.modulus;
               acc_q <= '0;   // the degenerate-modulus shortcut reports acc directly
               idx_q <= IW'(EXP_LEN - 1);
            end
            PRE_ISSUE: begin
               mul_a <= b0_q;
               mul_b <= b1_q;
            end
            PRE_CAP: begin
               b01_q <= mul_c;
               acc_q <= LEN'(1);
            end
            SQ_ISSUE: begin
               mul_a <= acc_q;
               mul_b <= acc_q;
            end
            SQ_CAP: begin
               acc_q <= mul_c;
               if (bits == SEL_NONE) begin
                  if (last_bit) begin
                     result_q    <= mul_c;
                     out_valid_q <= 1'b1;
                  end else begin
                     idx_q <= idx_q - IW'(1);
                  end
               end
            end
            MUL_ISSUE: begin
               mul_a <= acc_q;
               case (bits)
                  SEL_B0:  mul_b <= b0_q;
                  SEL_B1:  mul_b <= b1_q;
                  default: mul_b <= b01_q;
               endcase
            end
            MUL_CAP: begin
               acc_q <= mul_c;
               if (last_bit) begin
                  result_q    <= mul_c;
                  out_valid_q <= 1'b1;
               end else begin
                  idx_q <= idx_q - IW'(1);
               end
            end
            OUT: begin
               if (!out_valid_q) begin
                  result_q    <= acc_q;
                  out_valid_q <= 1'b1;
               end else if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = (state == IDLE);
   assign bus.busy      = (state != IDLE);
   assign bus.out_valid = out_valid_q;
   assign bus.result    = result_q;
endmodule
